// File: rtl/act_lut_pkg.sv
// Shared constants and interpolation math for the activation LUT unit.
// ACT_LUT_ROUND_EN selects round-half-up interpolation instead of floor.
package act_lut_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  function automatic int lut_depth(input int addr_w);
    return (1 << addr_w) + 1;
  endfunction

  function automatic int interp_prod(input int base, input int nxt, input int r);
    return (nxt - base) * r;
  endfunction

  function automatic int interp_out(input int base, input int prod, input int frac_w);
    int delta;
`ifdef ACT_LUT_ROUND_EN
    delta = (prod + (1 << (frac_w - 1))) >>> frac_w;
`else
    delta = prod >>> frac_w;
`endif
    return base + delta;
  endfunction

  function automatic int interp(input int base, input int nxt, input int r, input int frac_w);
    return interp_out(base, interp_prod(base, nxt, r), frac_w);
  endfunction

endpackage

// File: rtl/act_lut_table.sv
// Breakpoint register file: one write port, two combinational reads (idx, idx+1).
module act_lut_table
  import act_lut_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [DATA_W-1:0] rd_base,
  output logic [DATA_W-1:0] rd_next
);

  localparam int DEPTH = lut_depth(ADDR_W);
  localparam logic [ADDR_W:0] TOP_ADDR = (ADDR_W+1)'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   idx0, idx1;

  assign idx0    = {1'b0, rd_idx};
  assign idx1    = idx0 + (ADDR_W+1)'(1);
  assign rd_base = mem[idx0];
  assign rd_next = mem[idx1];

  // Addresses beyond the top entry are dropped rather than aliased.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && wr_addr <= TOP_ADDR) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/act_lut_interp_pipe.sv
// 3-stage LUT + linear-interpolation activation unit with valid/ready flow control.
// Build option: define ACT_LUT_ROUND_EN for round-half-up interpolation (default floor).
module act_lut_interp_pipe
  import act_lut_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  ADDR_W = DEF_ADDR_W,
  localparam int FRAC_W = DATA_W - ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int STAGES = 3;
  localparam int PROD_W = DATA_W + FRAC_W + 2;

  logic [STAGES:1]            vld_pipe;
  logic                       adv;
  logic [DATA_W-1:0]          rd_base, rd_next;
  logic signed [DATA_W-1:0]   s1_base, s1_next, s2_base;
  logic [FRAC_W-1:0]          s1_r;
  logic signed [PROD_W-1:0]   s2_prod, prod_c;
  logic [DATA_W-1:0]          out_q, out_c;

  act_lut_table #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_idx  (in_z[DATA_W-1:FRAC_W]),
    .rd_base (rd_base),
    .rd_next (rd_next)
  );

  // Whole pipe moves as one; a stalled output freezes every stage.
  assign adv       = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];
  assign out_a     = out_q;

  always_comb begin
    prod_c = PROD_W'(interp_prod(int'(s1_base), int'(s1_next), int'(s1_r)));
    out_c  = DATA_W'(interp_out(int'(s2_base), int'(s2_prod), FRAC_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_base  <= '0;
      s1_next  <= '0;
      s1_r     <= '0;
      s2_base  <= '0;
      s2_prod  <= '0;
      out_q    <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (in_valid) begin
        s1_base <= rd_base;
        s1_next <= rd_next;
        s1_r    <= in_z[FRAC_W-1:0];
      end
      if (vld_pipe[1]) begin
        s2_base <= s1_base;
        s2_prod <= prod_c;
      end
      if (vld_pipe[2]) out_q <= out_c;
    end
  end

endmodule
